fib_led_sequencer: RTL and testbench

- Downstream consumer of the Fibonacci datapath result.
- Accepts one DATA_WIDTH-bit term per valid/ready handshake and displays it on the board LED as N discrete blinks, where N is the term value.
- After the last blink it holds a fixed dark gap so consecutive terms are visually separable, then returns to idle for the next term.
- All on, off and gap intervals are counted in clock cycles by one internal interval counter.

---
 rtl/fib_pkg.sv | 17 +
 rtl/fib_led_sequencer_if.sv | 11 +
 rtl/blink_interval_cnt.sv | 28 ++
 rtl/fib_led_sequencer.sv | 111 +++++++++++
 tb/tb_fib_led_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared state encoding and default blink timing for the Fibonacci LED sequencer.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 13;
  localparam int DEF_ON_CYCLES  = 1600;
  localparam int DEF_OFF_CYCLES = 1599;
  localparam int DEF_GAP_CYCLES = 8000;

endpackage

// File: rtl/fib_led_sequencer_if.sv
// Term handshake between the Fibonacci datapath (master) and the LED sequencer (slave).
interface fib_led_sequencer_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/blink_interval_cnt.sv
// Shared interval counter: counts up from zero and flags the last cycle of the
// interval whose length the sequencer selects.
module blink_interval_cnt #(
  parameter int CNT_WIDTH = 13
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 clr_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  assign tc_o = (count_q == (limit_i - CNT_WIDTH'(1)));

  // Wrap to zero at terminal count so the next phase starts fresh.
  always_comb begin
    count_d = count_q + CNT_WIDTH'(1);
    if (clr_i || tc_o) count_d = '0;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/fib_led_sequencer.sv
// Shows each accepted term as N LED blinks followed by a dark gap, then
// pulses done_out and returns to idle for the next term.
module fib_led_sequencer
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clock_in,
  input  logic              reset_in,
  fib_led_sequencer_if.slave bus,
  output logic              led_out,
  output logic              done_out
);

  localparam logic [CNT_WIDTH-1:0] ON_LIM  = CNT_WIDTH'(ON_CYCLES);
  localparam logic [CNT_WIDTH-1:0] OFF_LIM = CNT_WIDTH'(OFF_CYCLES);
  localparam logic [CNT_WIDTH-1:0] GAP_LIM = CNT_WIDTH'(GAP_CYCLES);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  led_q, led_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  limit;
  logic                  tc;
  logic                  xfer;

  assign bus.ready_out = (state_q == ST_IDLE);
  assign xfer          = bus.valid_in && bus.ready_out;
  assign led_out       = led_q;
  assign done_out      = done_q;

  always_comb begin
    limit = ON_LIM;
    case (state_q)
      ST_OFF:  limit = OFF_LIM;
      ST_GAP:  limit = GAP_LIM;
      default: limit = ON_LIM;
    endcase
  end

  // Held in clear while idle so every term starts its first phase at zero.
  blink_interval_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_interval (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .clr_i   (state_q == ST_IDLE),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    led_d   = led_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          rem_d = bus.data_in;
          if (bus.data_in != '0) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
            led_d   = 1'b0;
          end
        end
      end
      ST_ON: begin
        if (tc) begin
          rem_d   = rem_q - DATA_WIDTH'(1);
          led_d   = 1'b0;
          state_d = (rem_q == DATA_WIDTH'(1)) ? ST_GAP : ST_OFF;
        end
      end
      ST_OFF: begin
        if (tc) begin
          state_d = ST_ON;
          led_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fib_led_sequencer.sv
// Directed and randomized checks of the LED sequencer against a blink-pattern model.
module tb_fib_led_sequencer;

  localparam int DW  = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 4;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;
  logic led_out;
  logic done_out;

  int errors = 0;
  int checks = 0;

  fib_led_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  fib_led_sequencer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (13),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .bus     (bus),
    .led_out (led_out),
    .done_out(done_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic int busy_len(int n);
    return (n == 0) ? GAP : n * ON + (n - 1) * OFF + GAP;
  endfunction

  // LED level in busy cycle k (1-based) of a term of value n.
  function automatic logic led_model(int n, int k);
    int j;
    j = k - 1;
    if (n == 0) return 1'b0;
    if (j >= n * ON + (n - 1) * OFF) return 1'b0;
    return ((j % (ON + OFF)) < ON);
  endfunction

  task automatic chk_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic idle(int m);
    bus.valid_in = 1'b0;
    for (int i = 0; i < m; i++) begin
      step();
      chk_bit("idle_led", led_out, 1'b0);
      chk_bit("idle_ready", bus.ready_out, 1'b1);
      chk_bit("idle_done", done_out, 1'b0);
    end
  endtask

  // Offer term n in the current (idle) cycle; returns in busy cycle 1.
  task automatic start(int n);
    chk_bit("ready_start", bus.ready_out, 1'b1);
    bus.valid_in = 1'b1;
    bus.data_in  = DW'(n);
    step();
  endtask

  // Checks every busy cycle and the done cycle of term n; returns in the done cycle.
  task automatic check_body(int n, bit noise, logic [DW-1:0] noise_data, bit keep);
    int   b;
    int   rises;
    logic prev;
    b     = busy_len(n);
    rises = 0;
    prev  = 1'b0;
    for (int k = 1; k <= b; k++) begin
      chk_bit("led", led_out, led_model(n, k));
      chk_bit("ready_busy", bus.ready_out, 1'b0);
      chk_bit("done_busy", done_out, 1'b0);
      if (led_out === 1'b1 && prev === 1'b0) rises++;
      prev = led_out;
      if (noise) begin
        bus.valid_in = 1'b1;
        bus.data_in  = noise_data;
      end else begin
        bus.valid_in = 1'b0;
      end
      step();
    end
    chk_bit("done_pulse", done_out, 1'b1);
    chk_bit("ready_done", bus.ready_out, 1'b1);
    chk_bit("led_done", led_out, 1'b0);
    chk_int("pulses", rises, n);
    if (!keep) bus.valid_in = 1'b0;
  endtask

  initial begin
    int n;
    bit nz;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    reset_in     = 1'b1;
    @(negedge clock_in);
    step();
    step();
    chk_bit("rst_led", led_out, 1'b0);
    chk_bit("rst_done", done_out, 1'b0);
    chk_bit("rst_ready", bus.ready_out, 1'b1);
    reset_in = 1'b0;
    idle(6);

    start(3);
    check_body(3, 1'b0, '0, 1'b0);
    idle(2);

    start(0);
    check_body(0, 1'b0, '0, 1'b0);
    idle(2);

    start(15);
    check_body(15, 1'b0, '0, 1'b0);
    start(1);
    check_body(1, 1'b0, '0, 1'b0);
    idle(2);

    // Term 3 with 7 offered every busy cycle; 7 is taken only in the done cycle.
    start(3);
    check_body(3, 1'b1, DW'(7), 1'b1);
    step();
    check_body(7, 1'b0, '0, 1'b0);
    idle(2);

    start(3);
    bus.valid_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_bit("mid_on_led", led_out, 1'b1);
    reset_in = 1'b1;
    step();
    chk_bit("abort_led", led_out, 1'b0);
    chk_bit("abort_ready", bus.ready_out, 1'b1);
    chk_bit("abort_done", done_out, 1'b0);
    reset_in = 1'b0;
    idle(8);
    start(2);
    check_body(2, 1'b0, '0, 1'b0);
    idle(1);

    for (int r = 0; r < 10; r++) begin
      n  = int'($urandom_range(15, 0));
      nz = 1'($urandom_range(1, 0));
      start(n);
      check_body(n, nz, DW'($urandom), 1'b0);
      idle(int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
